// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide/accumulate engine: op encoding,
// default latencies and the control state type.
package muldiv_pkg;

    localparam int unsigned OP_W        = 3;
    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_MUL_LAT = 5;
    localparam int unsigned DEF_DIV_LAT = 10;

    localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
    localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] OP_MADD  = 3'd4;
    localparam logic [OP_W-1:0] OP_MADDU = 3'd5;
    localparam logic [OP_W-1:0] OP_MSUB  = 3'd6;
    localparam logic [OP_W-1:0] OP_MSUBU = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Divides run on the long latency; every other op uses the multiplier latency.
    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Odd op codes are the unsigned variants.
    function automatic logic is_signed(input logic [OP_W-1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the E-stage and the multiply/divide engine.
interface muldiv_if #(
    parameter int unsigned WIDTH = muldiv_pkg::DEF_WIDTH
);
    logic                           start;
    logic [muldiv_pkg::OP_W-1:0]    op;
    logic [WIDTH-1:0]               a;
    logic [WIDTH-1:0]               b;
    logic                           flush;
    logic                           hi_we;
    logic                           lo_we;
    logic [WIDTH-1:0]               wdata;
    logic                           busy;
    logic                           done;
    logic                           dz;
    logic [WIDTH-1:0]               hi;
    logic [WIDTH-1:0]               lo;

    modport master (
        output start, op, a, b, flush, hi_we, lo_we, wdata,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hi_we, lo_we, wdata,
        output busy, done, dz, hi, lo
    );
endinterface

// File: rtl/muldiv_arith.sv
// Combinational datapath: computes the HI/LO value an op would commit, given the
// captured operands and the current accumulator, plus the divide-by-zero flag.
module muldiv_arith
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             dz
);

    localparam int unsigned DW = 2 * WIDTH;

    logic             sgn;
    logic [DW-1:0]    prod_s;
    logic [DW-1:0]    prod_u;
    logic [DW-1:0]    prod;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    res;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    // Products modulo 2^DW: sign-extending the operands yields the signed product.
    always_comb begin
        sgn    = is_signed(op);
        prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        prod   = sgn ? prod_s : prod_u;
        acc    = {hi, lo};
    end

    // Signed divide on magnitudes so MIN / -1 wraps back to MIN with a zero remainder.
    always_comb begin
        dz     = is_div(op) && (b == '0);
        a_neg  = sgn & a[WIDTH-1];
        b_neg  = sgn & b[WIDTH-1];
        a_mag  = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag  = b_neg ? (~b + WIDTH'(1)) : b;
        b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quo    = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
        rem    = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
    end

    always_comb begin
        res = acc;
        case (op)
            OP_MULT, OP_MULTU: res = prod;
            OP_DIV, OP_DIVU:   res = dz ? acc : {rem, quo};
            OP_MADD, OP_MADDU: res = acc + prod;
            OP_MSUB, OP_MSUBU: res = acc - prod;
            default:           res = acc;
        endcase
        hi_next = res[DW-1:WIDTH];
        lo_next = res[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_engine.sv
// Multiply/divide/accumulate engine owning HI/LO: multi-cycle ops with fixed
// latencies, one-cycle done pulse, divide-by-zero flag, flush and MTHI/MTLO.
module muldiv_engine
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT,
    parameter int unsigned DIV_LAT = DEF_DIV_LAT
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] lat;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic             dz_n;

    muldiv_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .a       (a_q),
        .b       (b_q),
        .op      (op_q),
        .hi      (hi_q),
        .lo      (lo_q),
        .hi_next (hi_n),
        .lo_next (lo_n),
        .dz      (dz_n)
    );

    assign lat = is_div(op_q) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

    // Next-state: flush beats commit and start; MTHI/MTLO only when idle with no start.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (!bus.flush) begin
                        a_d     = bus.a;
                        b_d     = bus.b;
                        op_d    = bus.op;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_BUSY;
                    end
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            ST_BUSY: begin
                if (bus.flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt == lat) begin
                    hi_d    = hi_n;
                    lo_d    = lo_n;
                    dz_d    = dz_n;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_W'(cnt + CNT_W'(1));
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= (state_d == ST_BUSY);
            done_q <= done_d;
            dz_q   <= dz_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dz   = dz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_engine.sv
// Self-checking bench for muldiv_engine: directed vector table, timing corner
// sequences, and random ops against an arithmetic reference model.
module tb_muldiv_engine;
    import muldiv_pkg::*;

    localparam int unsigned W    = 32;
    localparam int unsigned MLAT = 5;
    localparam int unsigned DLAT = 10;
    localparam int unsigned WIN  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus  ();
    muldiv_if #(.WIDTH(W)) bus1 ();

    muldiv_engine #(.WIDTH(W), .MUL_LAT(MLAT), .DIV_LAT(DLAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    muldiv_engine #(.WIDTH(W), .MUL_LAT(1), .DIV_LAT(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi0;
        logic [31:0] lo0;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [31:0] h, input logic [31:0] l);
        bus.hi_we = 1'b1; bus.wdata = h;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = l;
        tick();
        bus.lo_we = 1'b0;
    endtask

    // Launch one op and watch a fixed window, recording busy/done counts and the result.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output int ndone,
                          output logic [31:0] rhi, output logic [31:0] rlo, output logic rdz);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nbusy = 0; ndone = 0; rhi = bus.hi; rlo = bus.lo; rdz = 1'b0;
        for (int k = 0; k < int'(WIN); k++) begin
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                rhi = bus.hi; rlo = bus.lo; rdz = bus.dz;
            end
            tick();
        end
    endtask

    // Reference: plain 64-bit arithmetic straight from the op definitions.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi, input logic [31:0] lo,
                                  output logic [31:0] eh, output logic [31:0] el, output logic edz);
        int          ia = a;
        int          ib = b;
        longint      sq, sr;
        logic [63:0] acc = {hi, lo};
        logic [63:0] prod;
        logic [63:0] res;
        edz = 1'b0;
        res = acc;
        if (op[0]) prod = {32'h0, a} * {32'h0, b};
        else       prod = 64'(longint'(ia) * longint'(ib));
        case (op)
            3'd0, 3'd1: res = prod;
            3'd4, 3'd5: res = acc + prod;
            3'd6, 3'd7: res = acc - prod;
            3'd2: begin
                if (b == 0) edz = 1'b1;
                else begin
                    sq  = longint'(ia) / longint'(ib);
                    sr  = longint'(ia) % longint'(ib);
                    res = {32'(sr), 32'(sq)};
                end
            end
            default: begin
                if (b == 0) edz = 1'b1;
                else res = {a % b, a / b};
            end
        endcase
        eh = res[63:32];
        el = res[31:0];
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        return (op == 3'd2 || op == 3'd3) ? int'(DLAT) : int'(MLAT);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          nb, nd;
        logic [31:0] rh, rl, eh, el;
        logic        rdz, edz;
        logic [31:0] specials[6];

        vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'h0,    32'h0,    32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0};
        vecs[1]  = '{3'd7, 32'd2,         32'd7,        32'h0,    32'd10,   32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'h0,    32'h0,    32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{3'd3, 32'd7,         32'd0,        32'h1234, 32'h5678, 32'h1234,      32'h5678,      1'b1};
        vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,32'h1,    32'h2,    32'h0,         32'h8000_0000, 1'b0};
        vecs[5]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,32'h0,    32'h0,    32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[6]  = '{3'd4, 32'd1,         32'd1,        32'h0,    32'hFFFF_FFFF, 32'h1,    32'h0,         1'b0};
        vecs[7]  = '{3'd6, 32'hFFFF_FFFF, 32'd1,        32'h0,    32'h0,    32'h0,         32'h1,         1'b0};
        vecs[8]  = '{3'd3, 32'hFFFF_FFFF, 32'h10,       32'h0,    32'h0,    32'hF,         32'h0FFF_FFFF, 1'b0};
        vecs[9]  = '{3'd2, 32'd7,         32'hFFFF_FFFE,32'h0,    32'h0,    32'h1,         32'hFFFF_FFFD, 1'b0};
        vecs[10] = '{3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE,32'h0,    32'h0,    32'hFFFF_FFFF, 32'h3,         1'b0};
        vecs[11] = '{3'd5, 32'd1,         32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,       1'b0};
        vecs[12] = '{3'd2, 32'd5,         32'd0,        32'hABCD, 32'h4321, 32'hABCD,      32'h4321,      1'b1};

        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        bus1.start = 0; bus1.op = 0; bus1.a = 0; bus1.b = 0; bus1.flush = 0;
        bus1.hi_we = 0; bus1.lo_we = 0; bus1.wdata = 0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_dz",   bus.dz,   0);
        check("reset_hi",   bus.hi,   0);
        check("reset_lo",   bus.lo,   0);

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            preset(vecs[i].hi0, vecs[i].lo0);
            check($sformatf("vec%0d_preset_hi", i), bus.hi, vecs[i].hi0);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, nb, nd, rh, rl, rdz);
            check($sformatf("vec%0d_busy_cycles", i), 64'(nb), 64'(lat_of(vecs[i].op)));
            check($sformatf("vec%0d_done_pulses", i), 64'(nd), 64'd1);
            check($sformatf("vec%0d_hi", i), rh, vecs[i].ehi);
            check($sformatf("vec%0d_lo", i), rl, vecs[i].elo);
            check($sformatf("vec%0d_dz", i), rdz, vecs[i].edz);
            check($sformatf("vec%0d_dz_after", i), bus.dz, 0);
        end

        // Flush at the third busy cycle; HI/LO held, restart right away.
        preset(32'hAAAA, 32'hBBBB);
        bus.op = 3'd1; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        check("flush_busy_before", bus.busy, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        check("flush_done", bus.done, 0);
        check("flush_hi",   bus.hi,   32'hAAAA);
        check("flush_lo",   bus.lo,   32'hBBBB);
        run_op(3'd0, 32'd4, 32'd5, nb, nd, rh, rl, rdz);
        check("after_flush_busy_cycles", 64'(nb), 64'(MLAT));
        check("after_flush_done_pulses", 64'(nd), 1);
        check("after_flush_lo", rl, 32'd20);

        // Flush coincident with start while idle drops the start.
        bus.flush = 1'b1; bus.start = 1'b1; bus.op = 3'd0;
        tick();
        bus.flush = 1'b0; bus.start = 1'b0;
        check("flush_start_busy", bus.busy, 0);

        // Flush on the commit edge discards the result.
        preset(32'h1111, 32'h2222);
        bus.op = 3'd0; bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (MLAT - 1) tick();
        check("commit_flush_busy_before", bus.busy, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("commit_flush_busy", bus.busy, 0);
        check("commit_flush_done", bus.done, 0);
        check("commit_flush_lo",   bus.lo,   32'h2222);
        tick();
        check("commit_flush_done_late", bus.done, 0);

        // Start and MTHI during busy are ignored; MTHI+MTLO afterwards writes both.
        preset(32'h11, 32'h22);
        bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1; bus.a = 32'd2; bus.b = 32'd2; bus.hi_we = 1'b1; bus.wdata = 32'h55;
        tick();
        bus.start = 1'b0; bus.hi_we = 1'b0;
        check("busy_mthi_dropped", bus.hi, 32'h11);
        nd = 0;
        for (int k = 0; k < int'(WIN) && nd == 0; k++) begin
            if (bus.done) begin
                nd = 1; rh = bus.hi; rl = bus.lo;
            end else tick();
        end
        check("busy_ignore_done_seen", 64'(nd), 1);
        check("busy_ignore_hi", rh, 32'h0);
        check("busy_ignore_lo", rl, 32'd15);
        tick();
        check("no_queued_start", bus.busy, 0);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h55;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("mthi_mtlo_hi", bus.hi, 32'h55);
        check("mthi_mtlo_lo", bus.lo, 32'h55);

        // Start held high: ignored at the commit edge, accepted one edge later.
        bus.op = 3'd0; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
        tick();
        repeat (MLAT - 1) tick();
        check("b2b_busy_last", bus.busy, 1);
        tick();
        check("b2b_busy_gap", bus.busy, 0);
        check("b2b_done",     bus.done, 1);
        check("b2b_lo",       bus.lo,   32'd6);
        tick();
        bus.start = 1'b0;
        check("b2b_busy_restart", bus.busy, 1);
        repeat (WIN) tick();
        check("b2b_idle", bus.busy, 0);

        // Reset in the middle of a divide.
        preset(32'h99, 32'h77);
        bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_busy", bus.busy, 0);
        check("mid_reset_done", bus.done, 0);
        check("mid_reset_dz",   bus.dz,   0);
        check("mid_reset_hi",   bus.hi,   0);
        check("mid_reset_lo",   bus.lo,   0);
        nd = 0;
        for (int k = 0; k < int'(WIN); k++) begin
            if (bus.done) nd++;
            tick();
        end
        check("mid_reset_no_done", 64'(nd), 0);

        // Latency-1 instance: busy for exactly one cycle.
        bus1.op = 3'd0; bus1.a = 32'd6; bus1.b = 32'd7; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("lat1_busy_first", bus1.busy, 1);
        nb = 0; nd = 0; rl = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus1.busy) nb++;
            if (bus1.done) begin nd++; rl = bus1.lo; end
            tick();
        end
        check("lat1_busy_cycles", 64'(nb), 1);
        check("lat1_done_pulses", 64'(nd), 1);
        check("lat1_lo", rl, 32'd42);

        // Random ops against the reference model.
        specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF; specials[5] = 32'h2;
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b, h0, l0;
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            h0 = $urandom;
            l0 = $urandom;
            preset(h0, l0);
            model(op, a, b, h0, l0, eh, el, edz);
            run_op(op, a, b, nb, nd, rh, rl, rdz);
            check($sformatf("rand%0d_op%0d_busy", i, op), 64'(nb), 64'(lat_of(op)));
            check($sformatf("rand%0d_op%0d_done", i, op), 64'(nd), 1);
            check($sformatf("rand%0d_op%0d_hi", i, op), rh, eh);
            check($sformatf("rand%0d_op%0d_lo", i, op), rl, el);
            check($sformatf("rand%0d_op%0d_dz", i, op), rdz, edz);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
